// File: rtl/lut_gate_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lut_gate_pkg
// Brief    : Shared constants and helpers for the LUT gate pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package lut_gate_pkg;

    // Minterms 1,3,9,11 -> F = ~B & D
    localparam logic [15:0] c_DEFAULT_LUT = 16'h0A0A;

    // Select width that never collapses to zero bits for a single channel
    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/lut_channel.sv
`default_nettype none
// ============================================================================
// Module   : lut_channel
// Brief    : One programmable truth table with rise detection and hit counter.
// Revision : 1.0 - initial release
// ============================================================================
module lut_channel #(
    parameter int                   N_IN    = 4,
    parameter int                   CNT_W   = 8,
    parameter logic [(1<<N_IN)-1:0] RST_LUT = '0
) (
    input  logic                   clk,
    input  logic                   i_rst_n,
    input  logic                   i_cfg_we,
    input  logic [(1<<N_IN)-1:0]   i_cfg_data,
    input  logic                   i_cnt_clr,
    input  logic                   i_acc,
    input  logic [N_IN-1:0]        i_data,
    output logic                   o_f_next,
    output logic                   o_rise_next,
    output logic [CNT_W-1:0]       o_hit_cnt
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = '1;

    logic [(1<<N_IN)-1:0] r_lut;
    logic                 r_prev_f;
    logic [CNT_W-1:0]     r_cnt;

    // Lookup reads the current table, so a same-cycle write only affects later accepts
    assign o_f_next    = r_lut[i_data];
    assign o_rise_next = o_f_next & ~r_prev_f;
    assign o_hit_cnt   = r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_lut    <= RST_LUT;
            r_prev_f <= 1'b0;
            r_cnt    <= '0;
        end else begin
            if (i_cfg_we) begin
                r_lut <= i_cfg_data;
            end
            if (i_acc) begin
                r_prev_f <= o_f_next;
            end
            // Clear wins over a coincident hit
            if (i_cnt_clr) begin
                r_cnt <= '0;
            end else if (i_acc && o_f_next && (r_cnt != c_CNT_MAX)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/lut_gate_pipe.sv
`default_nettype none
// ============================================================================
// Module   : lut_gate_pipe
// Brief    : N_CH programmable LUT gates behind a valid/ready output register.
// Revision : 1.0 - initial release
// ============================================================================
module lut_gate_pipe
    import lut_gate_pkg::*;
#(
    parameter int                   N_IN        = 4,
    parameter int                   N_CH        = 2,
    parameter int                   CNT_W       = 8,
    parameter logic [(1<<N_IN)-1:0] DEFAULT_LUT = c_DEFAULT_LUT
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          CFG_WE,
    input  logic [sel_width(N_CH)-1:0]    CFG_CH,
    input  logic [(1<<N_IN)-1:0]          CFG_DATA,
    input  logic                          CNT_CLR,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    input  logic [N_IN-1:0]               IN_DATA,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [N_CH-1:0]               OUT_F,
    output logic [N_CH-1:0]               OUT_RISE,
    output logic [N_CH*CNT_W-1:0]         HIT_CNT
);

    localparam int c_W_SEL = sel_width(N_CH);

    logic            w_accept;
    logic [N_CH-1:0] w_cfg_we;
    logic [N_CH-1:0] w_f_next;
    logic [N_CH-1:0] w_rise_next;

    logic            r_out_valid;
    logic [N_CH-1:0] r_out_f;
    logic [N_CH-1:0] r_out_rise;

    assign IN_READY = !r_out_valid || OUT_READY;
    assign w_accept = IN_VALID && IN_READY;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        // Out-of-range CFG_CH matches no channel, so the write is dropped
        assign w_cfg_we[c] = CFG_WE && (CFG_CH == c_W_SEL'(c));

        lut_channel #(
            .N_IN    (N_IN),
            .CNT_W   (CNT_W),
            .RST_LUT (DEFAULT_LUT)
        ) u_ch (
            .clk         (CLK),
            .i_rst_n     (RST_N),
            .i_cfg_we    (w_cfg_we[c]),
            .i_cfg_data  (CFG_DATA),
            .i_cnt_clr   (CNT_CLR),
            .i_acc       (w_accept),
            .i_data      (IN_DATA),
            .o_f_next    (w_f_next[c]),
            .o_rise_next (w_rise_next[c]),
            .o_hit_cnt   (HIT_CNT[c*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_out_valid <= 1'b0;
            r_out_f     <= '0;
            r_out_rise  <= '0;
        end else if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_f     <= w_f_next;
            r_out_rise  <= w_rise_next;
        end else if (OUT_READY) begin
            r_out_valid <= 1'b0;
        end
    end

    assign OUT_VALID = r_out_valid;
    assign OUT_F     = r_out_f;
    assign OUT_RISE  = r_out_rise;

endmodule
`default_nettype wire
